sequence_generator: RTL and testbench

SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

---
 rtl/seq_pkg.sv | 29 ++
 rtl/seq_bit_counter.sv | 105 ++++++++++
 rtl/sequence_generator.sv | 131 +++++++++++++
 tb/tb_sequence_generator.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the serial sequence generator:
//   gen_state_t    - controller states (IDLE / SHIFT / DONE)
//   DEF_PATTERN_C  - pattern sent when the requested pattern is all-zero
//                    (held 32 bits wide, narrowed to PAT_W by the user)
//   idxWidth()     - width of a bit index able to address PAT_W bits
// ---------------------------------------------------------------------------
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } gen_state_t;

  localparam logic [31:0] DEF_PATTERN_C = 32'b10100;

  // An index into PAT_W bits needs clog2(PAT_W) bits, never fewer than one.
  function automatic int idxWidth(input int patW);
    int w;
    w = $clog2(patW);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/seq_bit_counter.sv
// ---------------------------------------------------------------------------
// seq_bit_counter
// Bit-index down-counter plus optional repeat down-counter for the sequence
// generator. The index walks PAT_W-1 .. 0 once per pattern; at index 0 it
// reloads to PAT_W-1 while repetitions remain.
//
// Configuration macro: SEQGEN_REPEAT_EN
//   defined   - a repeat count register is kept and patterns repeat
//   undefined - no count register exists; count_i is ignored and every
//               load produces exactly one pattern
//
// Ports:
//   clk      - clock, rising edge
//   reset    - asynchronous active-high reset, clears index and count
//   load_i   - start a new request: index <= PAT_W-1, count <= count_i
//   dec_i    - advance by one bit
//   count_i  - number of extra repetitions captured on load_i
//   index_o  - current bit index (MSB first, so counts down)
//   last_o   - current bit is the final bit of the whole request
// ---------------------------------------------------------------------------
module seq_bit_counter
  import seq_pkg::*;
#(
  parameter int PAT_W = 5,
  parameter int CNT_W = 4,
  parameter int IDX_W = idxWidth(PAT_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] count_i,
  output logic [IDX_W-1:0] index_o,
  output logic             last_o
);

  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(PAT_W - 1);

  logic [IDX_W-1:0] indexQ, indexD;
  logic             idxZero;
  logic             repeatLeft;

  assign idxZero = (indexQ == '0);

`ifdef SEQGEN_REPEAT_EN

  logic [CNT_W-1:0] countQ, countD;

  assign repeatLeft = (countQ != '0);

  // The count only moves at a pattern boundary, and only while non-zero,
  // so it can never wrap below zero.
  always_comb begin
    countD = countQ;
    if (load_i) begin
      countD = count_i;
    end else if (dec_i && idxZero && repeatLeft) begin
      countD = countQ - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      countQ <= '0;
    end else begin
      countQ <= countD;
    end
  end

`else

  // Without repeat support the count input is deliberately left unused.
  logic unusedCount;
  assign unusedCount = ^count_i;
  assign repeatLeft  = 1'b0;

`endif

  // At index 0 the index either reloads for another pattern or holds; it
  // holds on the final bit because the controller leaves SHIFT there.
  always_comb begin
    indexD = indexQ;
    if (load_i) begin
      indexD = TOP_IDX;
    end else if (dec_i) begin
      if (!idxZero) begin
        indexD = indexQ - IDX_W'(1);
      end else if (repeatLeft) begin
        indexD = TOP_IDX;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      indexQ <= '0;
    end else begin
      indexQ <= indexD;
    end
  end

  assign index_o = indexQ;
  assign last_o  = idxZero && !repeatLeft;

endmodule

// File: rtl/sequence_generator.sv
// ---------------------------------------------------------------------------
// sequence_generator
// Serialises a PAT_W-bit pattern MSB first on outBit/outValid after a
// valid/ready handshake, optionally repeating it back-to-back, and pulses
// done for one cycle when the whole request has been sent. An abort during
// transmission drops straight back to idle without a done pulse.
//
// Configuration macro: SEQGEN_REPEAT_EN
//   defined   - repeatIn extra copies of the pattern follow the first one
//   undefined - repeatIn is ignored, one pattern per request
//
// Parameters:
//   PAT_W        - pattern width (2..32)
//   CNT_W        - repeat-count width
//   DEF_PATTERN  - pattern substituted when patternIn is all-zero
//
// Ports:
//   clk         - clock, rising edge
//   reset       - asynchronous active-high reset
//   startValid  - request to send a pattern
//   startReady  - high while idle, i.e. a request can be accepted
//   patternIn   - pattern to send, MSB first
//   repeatIn    - number of extra back-to-back repetitions
//   abort       - terminate an in-progress transmission
//   outBit      - serial data, forced to 0 when outValid is low
//   outValid    - qualifies outBit
//   done        - one-cycle completion pulse
// ---------------------------------------------------------------------------
module sequence_generator
  import seq_pkg::*;
#(
  parameter int               PAT_W       = 5,
  parameter int               CNT_W       = 4,
  parameter logic [PAT_W-1:0] DEF_PATTERN = PAT_W'(DEF_PATTERN_C)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startValid,
  output logic             startReady,
  input  logic [PAT_W-1:0] patternIn,
  input  logic [CNT_W-1:0] repeatIn,
  input  logic             abort,
  output logic             outBit,
  output logic             outValid,
  output logic             done
);

  localparam int IDX_W = idxWidth(PAT_W);

  gen_state_t       stateQ, stateD;
  logic [PAT_W-1:0] patternQ, patternD;
  logic             loadCnt;
  logic             decCnt;
  logic [IDX_W-1:0] bitIndex;
  logic             lastBit;

  seq_bit_counter #(
    .PAT_W (PAT_W),
    .CNT_W (CNT_W),
    .IDX_W (IDX_W)
  ) uBitCounter (
    .clk     (clk),
    .reset   (reset),
    .load_i  (loadCnt),
    .dec_i   (decCnt),
    .count_i (repeatIn),
    .index_o (bitIndex),
    .last_o  (lastBit)
  );

  // Controller next state and outputs. All outputs are decoded from the
  // current state, so an asynchronous reset clears them immediately.
  // Abort is tested before the last-bit condition so it always wins.
  always_comb begin
    stateD     = stateQ;
    loadCnt    = 1'b0;
    decCnt     = 1'b0;
    startReady = 1'b0;
    outValid   = 1'b0;
    outBit     = 1'b0;
    done       = 1'b0;
    case (stateQ)
      IDLE: begin
        startReady = 1'b1;
        if (startValid) begin
          loadCnt = 1'b1;
          stateD  = SHIFT;
        end
      end
      SHIFT: begin
        outValid = 1'b1;
        outBit   = patternQ[bitIndex];
        if (abort) begin
          stateD = IDLE;
        end else begin
          decCnt = 1'b1;
          if (lastBit) begin
            stateD = DONE;
          end
        end
      end
      DONE: begin
        done   = 1'b1;
        stateD = IDLE;
      end
      default: begin
        stateD = IDLE;
      end
    endcase
  end

  // The pattern is captured only at acceptance; a zero request is replaced
  // by the default pattern so the line never carries an all-zero frame.
  always_comb begin
    patternD = patternQ;
    if (loadCnt) begin
      patternD = (patternIn == '0) ? DEF_PATTERN : patternIn;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ   <= IDLE;
      patternQ <= '0;
    end else begin
      stateQ   <= stateD;
      patternQ <= patternD;
    end
  end

endmodule

// File: tb/tb_sequence_generator.sv
// Self-checking bench for sequence_generator (default parameters PAT_W=5,
// CNT_W=4). Works with SEQGEN_REPEAT_EN either defined or undefined.
module tb_sequence_generator;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       startValid = 1'b0;
  logic       startReady;
  logic [4:0] patternIn = '0;
  logic [3:0] repeatIn = '0;
  logic       abort = 1'b0;
  logic       outBit;
  logic       outValid;
  logic       done;

  int total = 0;
  int bad   = 0;

  sequence_generator dut (
    .clk        (clk),
    .reset      (reset),
    .startValid (startValid),
    .startReady (startReady),
    .patternIn  (patternIn),
    .repeatIn   (repeatIn),
    .abort      (abort),
    .outBit     (outBit),
    .outValid   (outValid),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit sv, input logic [4:0] pat,
                               input logic [3:0] rep, input bit ab);
    startValid = sv;
    patternIn  = pat;
    repeatIn   = rep;
    abort      = ab;
  endtask

  // Inputs change 1 time unit after each rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: a queue of the bits still owed to the line plus a
  // phase (0 idle, 1 sending, 2 done pulse). Compared on every falling edge,
  // then advanced with the inputs the DUT will sample on the next rising edge.
  bit expQ[$];
  int phase = 0;

  initial begin : compareProc
    logic [4:0] p;
    int         reps;
    forever begin
      @(negedge clk);
      if (reset) begin
        expQ.delete();
        phase = 0;
      end else begin
        checkOutput("startReady", startReady, phase == 0);
        checkOutput("outValid", outValid, phase == 1);
        checkOutput("outBit", outBit, (phase == 1) ? expQ[0] : 1'b0);
        checkOutput("done", done, phase == 2);
        if (phase == 0) begin
          if (startValid) begin
            p = (patternIn == 5'd0) ? 5'b10100 : patternIn;
`ifdef SEQGEN_REPEAT_EN
            reps = int'(repeatIn);
`else
            reps = 0;
`endif
            for (int r = 0; r <= reps; r++) begin
              for (int i = 4; i >= 0; i--) begin
                expQ.push_back(p[i]);
              end
            end
            phase = 1;
          end
        end else if (phase == 1) begin
          if (abort) begin
            expQ.delete();
            phase = 0;
          end else begin
            void'(expQ.pop_front());
            if (expQ.size() == 0) begin
              phase = 2;
            end
          end
        end else begin
          phase = 0;
        end
      end
    end
  end

  // Sends one request and records what appears on the line until the DUT
  // is ready again. abortAt>0 raises abort during that bit number.
  task automatic runTransfer(input logic [4:0] pat, input logic [3:0] rep,
                             input int abortAt, input bit holdStart,
                             output logic [63:0] bits, output int nbits,
                             output int doneCnt, output bit firstValid);
    int guard;
    bits = '0;
    nbits = 0;
    doneCnt = 0;
    firstValid = 1'b0;
    guard = 0;
    while (!startReady && guard < 300) begin
      stepCycle();
      guard++;
    end
    if (!startReady) begin
      checkOutput("ready_timeout", 0, 1);
      return;
    end
    applyStimulus(1'b1, pat, rep, 1'b0);
    stepCycle();
    firstValid = outValid;
    if (!holdStart) begin
      startValid = 1'b0;
    end
    guard = 0;
    while (guard < 300) begin
      abort = 1'b0;
      if (outValid) begin
        bits = {bits[62:0], outBit};
        nbits++;
        if (nbits == abortAt) begin
          abort = 1'b1;
        end
      end
      if (done) begin
        doneCnt++;
      end
      if (startReady) begin
        break;
      end
      stepCycle();
      guard++;
    end
    if (guard >= 300) begin
      checkOutput("xfer_timeout", 0, 1);
    end
  endtask

  task automatic waitIdle();
    int guard;
    guard = 0;
    while (!startReady && guard < 300) begin
      stepCycle();
      guard++;
    end
    checkOutput("idle_reached", startReady, 1'b1);
  endtask

  initial begin : watchdog
    #300000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : mainProc
    logic [63:0] bits;
    int          nbits;
    int          doneCnt;
    bit          firstValid;

    // Reset state
    repeat (3) @(posedge clk);
    #3;
    checkOutput("rst_startReady", startReady, 1'b1);
    checkOutput("rst_outValid", outValid, 1'b0);
    checkOutput("rst_outBit", outBit, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Basic pattern, accepted on the first edge after reset release
    runTransfer(5'b10100, 4'd0, 0, 1'b0, bits, nbits, doneCnt, firstValid);
    checkOutput("basic_first", firstValid, 1'b1);
    checkOutput("basic_bits", bits, 64'b10100);
    checkOutput("basic_nbits", nbits, 5);
    checkOutput("basic_done", doneCnt, 1);

    // Zero pattern substitutes the default
    runTransfer(5'b00000, 4'd0, 0, 1'b0, bits, nbits, doneCnt, firstValid);
    checkOutput("default_bits", bits, 64'b10100);
    checkOutput("default_nbits", nbits, 5);

    // Repeated pattern
    runTransfer(5'b11001, 4'd2, 0, 1'b0, bits, nbits, doneCnt, firstValid);
`ifdef SEQGEN_REPEAT_EN
    checkOutput("repeat_bits", bits, 64'b110011100111001);
    checkOutput("repeat_nbits", nbits, 15);
`else
    checkOutput("repeat_bits", bits, 64'b11001);
    checkOutput("repeat_nbits", nbits, 5);
`endif
    checkOutput("repeat_done", doneCnt, 1);

    // Abort during the third bit
    runTransfer(5'b01111, 4'd3, 3, 1'b0, bits, nbits, doneCnt, firstValid);
    checkOutput("abort_bits", bits, 64'b011);
    checkOutput("abort_nbits", nbits, 3);
    checkOutput("abort_done", doneCnt, 0);
    checkOutput("abort_outValid", outValid, 1'b0);
    checkOutput("abort_ready", startReady, 1'b1);

    // startValid held high: no queued request, restart only after done
    runTransfer(5'b10011, 4'd0, 0, 1'b1, bits, nbits, doneCnt, firstValid);
    checkOutput("hold_bits", bits, 64'b10011);
    checkOutput("hold_done", doneCnt, 1);
    checkOutput("hold_gapValid", outValid, 1'b0);
    stepCycle();
    checkOutput("hold_restart", outValid, 1'b1);
    startValid = 1'b0;
    waitIdle();

    // Reset in the middle of a transmission
    applyStimulus(1'b1, 5'b11111, 4'd5, 1'b0);
    stepCycle();
    startValid = 1'b0;
    stepCycle();
    checkOutput("midrst_pre", outValid, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("midrst_outValid", outValid, 1'b0);
    checkOutput("midrst_outBit", outBit, 1'b0);
    checkOutput("midrst_done", done, 1'b0);
    checkOutput("midrst_ready", startReady, 1'b1);
    stepCycle();
    reset = 1'b0;
    stepCycle();
    checkOutput("postrst_done", done, 1'b0);

    // Randomised traffic, checked every cycle by the model
    for (int c = 0; c < 800; c++) begin
      applyStimulus($urandom_range(0, 1) == 1,
                    ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                    4'($urandom),
                    $urandom_range(0, 11) == 0);
      stepCycle();
    end
    applyStimulus(1'b0, 5'd0, 4'd0, 1'b0);
    waitIdle();
    stepCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
